// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - shared constants and width helper for the sigmoid/tanh pipeline
package sigmoid_pkg;

    localparam logic MODE_SIGMOID = 1'b0;
    localparam logic MODE_TANH    = 1'b1;

    localparam int SIGMOID_LATENCY = 3;

    // Width of d = K - min(|x|, K), where K = 2^(fbit+sat_log2) needs one extra bit.
    function automatic int sig_d_width(input int fbit, input int sat_log2);
        return fbit + sat_log2 + 1;
    endfunction

endpackage

// File: rtl/sig_square.sv
// rtl/sig_square.sv - unsigned registered squarer, one cycle latency, clock-enabled
module sig_square #(
    parameter int W = 13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic [W-1:0]   a,
    output logic [2*W-1:0] p
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (ce) begin
            p <= (2*W)'(a) * (2*W)'(a);
        end
    end

endmodule

// File: rtl/sigmoid_pipe.sv
// rtl/sigmoid_pipe.sv - 3-stage piecewise-quadratic sigmoid/tanh; tanh path built only with SIGMOID_TANH_EN
module sigmoid_pipe
    import sigmoid_pkg::*;
#(
    parameter int IBIT     = 32,
    parameter int FBIT     = 10,
    parameter int OBIT     = 12,
    parameter int SAT_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   dv_in,
    input  logic                   mode,
    input  logic signed [IBIT-1:0] sigin,
    output logic                   dv_out,
    output logic signed [OBIT-1:0] sigout
);

    localparam int DW  = sig_d_width(FBIT, SAT_LOG2);
    localparam int SQW = 2 * DW;
    localparam int SH  = FBIT + 2 * SAT_LOG2 + 1;
    localparam int TW  = FBIT + 1;
    localparam int YW  = FBIT + 3;
`ifdef SIGMOID_TANH_EN
    localparam int XW  = IBIT + 1;
`else
    localparam int XW  = IBIT;
`endif

    localparam logic [XW-1:0]         K_X   = XW'(1) << (FBIT + SAT_LOG2);
    localparam logic [DW-1:0]         K_D   = DW'(1) << (FBIT + SAT_LOG2);
    localparam logic [SQW-1:0]        RND   = SQW'(1) << (FBIT + 2 * SAT_LOG2);
    localparam logic signed [YW-1:0]  ONE   = YW'(1) << FBIT;
    localparam logic signed [YW-1:0]  Y_MAX = ONE - YW'(1);
    localparam logic signed [YW-1:0]  Y_MIN = -Y_MAX;

    // Stage 1: |x| is taken in XW bits so the most negative input negates without overflow.
    logic signed [XW-1:0] x;
    logic [XW-1:0]        ax;
    logic [DW-1:0]        a_sat;
    logic                 neg_x;

`ifdef SIGMOID_TANH_EN
    assign x = (mode == MODE_TANH) ? {sigin, 1'b0} : {sigin[IBIT-1], sigin};
`else
    assign x = sigin;
`endif
    assign neg_x = x[XW-1];
    assign ax    = neg_x ? (~x + XW'(1)) : x;
    assign a_sat = (ax >= K_X) ? K_D : ax[DW-1:0];

    logic          v1, neg1;
    logic [DW-1:0] d1;
    logic          v2, neg2;
    logic [SQW-1:0] sq2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            neg1 <= 1'b0;
            d1   <= '0;
            v2   <= 1'b0;
            neg2 <= 1'b0;
        end else if (ce) begin
            v1   <= dv_in;
            neg1 <= neg_x;
            d1   <= K_D - a_sat;
            v2   <= v1;
            neg2 <= neg1;
        end
    end

`ifdef SIGMOID_TANH_EN
    logic mode1, mode2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode1 <= MODE_SIGMOID;
            mode2 <= MODE_SIGMOID;
        end else if (ce) begin
            mode1 <= mode;
            mode2 <= mode1;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // Stage 2: squaring of d, registered inside the squarer.
    sig_square #(
        .W (DW)
    ) u_square (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .a   (d1),
        .p   (sq2)
    );

    // Stage 3: t = 0.5*(d/L)^2 rounded half-up, then fold by sign and clamp.
    logic [TW-1:0]        t3;
    logic signed [YW-1:0] t_s, y_raw, y_clamp;

    assign t3  = TW'((sq2 + RND) >> SH);
    assign t_s = $signed({2'b00, t3});

    always_comb begin
        y_raw = neg2 ? t_s : (ONE - t_s);
`ifdef SIGMOID_TANH_EN
        if (mode2 == MODE_TANH) begin
            y_raw = neg2 ? ((t_s <<< 1) - ONE) : (ONE - (t_s <<< 1));
        end
`endif
        y_clamp = y_raw;
        if (y_raw > Y_MAX) begin
            y_clamp = Y_MAX;
        end else if (y_raw < Y_MIN) begin
            y_clamp = Y_MIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_out <= 1'b0;
            sigout <= '0;
        end else if (ce) begin
            dv_out <= v2;
            if (v2) begin
                sigout <= OBIT'(y_clamp);
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// tb/tb_sigmoid_pipe.sv - directed and streaming checks of sigmoid_pipe against hand values and a reference model
module tb_sigmoid_pipe;

    localparam int IBIT     = 32;
    localparam int FBIT     = 10;
    localparam int OBIT     = 12;
    localparam int SAT_LOG2 = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ce;
    logic                   dv_in;
    logic                   mode;
    logic [IBIT-1:0]        sigin;
    logic                   dv_out;
    logic [OBIT-1:0]        sigout;

    int    n_chk  = 0;
    int    n_pass = 0;
    string phase  = "init";

    bit pv [3];
    int pe [3];
    int exp_sig = 0;
    int nxt_exp = 0;

    always #5 clk = ~clk;

    sigmoid_pipe #(
        .IBIT     (IBIT),
        .FBIT     (FBIT),
        .OBIT     (OBIT),
        .SAT_LOG2 (SAT_LOG2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .dv_in  (dv_in),
        .mode   (mode),
        .sigin  (sigin),
        .dv_out (dv_out),
        .sigout (sigout)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s/%s: got %0d expected %0d", phase, tag, got, exp);
    endtask

    function automatic int ref_model(input int s, input bit m);
        longint x, ax, d, t, y;
        bit tanh_m;
`ifdef SIGMOID_TANH_EN
        tanh_m = m;
`else
        tanh_m = 1'b0;
`endif
        x  = tanh_m ? 2 * longint'(s) : longint'(s);
        ax = (x < 0) ? -x : x;
        if (ax > 4096) ax = 4096;
        d = 4096 - ax;
        t = (d * d + 16384) / 32768;
        if (tanh_m) y = (x < 0) ? 2 * t - 1024 : 1024 - 2 * t;
        else        y = (x < 0) ? t : 1024 - t;
        if (y > 1023)  y = 1023;
        if (y < -1023) y = -1023;
        return int'(y);
    endfunction

    // One clock: advance the 3-deep expectation pipe like the DUT, then check both outputs.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                pv[i] = 1'b0;
                pe[i] = 0;
            end
            exp_sig = 0;
        end else if (ce) begin
            pv[2] = pv[1]; pe[2] = pe[1];
            pv[1] = pv[0]; pe[1] = pe[0];
            pv[0] = dv_in; pe[0] = nxt_exp;
            if (pv[2]) exp_sig = pe[2];
        end
        #1;
        check("dv_out", int'(dv_out), int'(pv[2]));
        check("sigout", int'($signed(sigout)), exp_sig);
    endtask

    task automatic put(input logic [IBIT-1:0] v, input bit m, input int e);
        dv_in   = 1'b1;
        sigin   = v;
        mode    = m;
        nxt_exp = e;
        tick();
    endtask

    task automatic idle(input int n);
        dv_in   = 1'b0;
        nxt_exp = 0;
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; dv_in = 1'b1; mode = 1'b0; sigin = 32'd1024;
        phase = "reset";
        repeat (4) tick();
        rst = 1'b0;
        put(32'd0, 1'b0, 512);
        idle(4);

        phase = "sigmoid";
        put(32'd1024, 1'b0, 736);
        put(-32'sd1024, 1'b0, 288);
        put(32'd5120, 1'b0, 1023);
        put(-32'sd5120, 1'b0, 0);
        put(-32'sd1, 1'b0, 512);
        put(32'h8000_0000, 1'b0, 0);
        idle(4);

        phase = "tanh";
`ifdef SIGMOID_TANH_EN
        put(32'd1024, 1'b1, 768);
        put(-32'sd1024, 1'b1, -768);
        put(32'd0, 1'b1, 0);
        put(32'd4096, 1'b1, 1023);
        put(32'h8000_0000, 1'b1, -1023);
`else
        put(32'd1024, 1'b1, 736);
        put(-32'sd1024, 1'b1, 288);
        put(32'd0, 1'b1, 512);
        put(32'd4096, 1'b1, 1023);
        put(32'h8000_0000, 1'b1, 0);
`endif
        idle(4);

        phase = "stream";
        for (int i = 0; i < 1000; i++) begin
            int v;
            bit m;
            v = int'($urandom_range(0, 12000)) - 6000;
            if (i % 50 == 0) v = int'($urandom);
            m = 1'($urandom_range(0, 1));
            put(v, m, ref_model(v, m));
        end
        idle(4);

        phase = "stall";
        put(32'd1024, 1'b0, 736);
        put(-32'sd1024, 1'b0, 288);
        ce = 1'b0; dv_in = 1'b1; sigin = 32'd5; nxt_exp = 0;
        repeat (5) tick();
        ce = 1'b1;
        idle(4);

        phase = "midrst";
        put(32'd100, 1'b0, ref_model(100, 1'b0));
        put(-32'sd300, 1'b0, ref_model(-300, 1'b0));
        put(32'd2000, 1'b0, ref_model(2000, 1'b0));
        dv_in = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(5);
        put(32'd0, 1'b0, 512);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sigmoid_pipe.md
# sigmoid_pipe

Fully pipelined, parametrised sigmoid/tanh activation unit for the DNN datapath. It accepts one signed fixed-point sample per cycle and returns the activation a fixed 3 cycles later. It uses a symmetric piecewise-quadratic approximation with saturation instead of a multi-cycle, multiplier-IP sequencer. It sits between the neuron accumulator and the next layer's input buffer.

## Interface
- IBIT, 32: input width, signed, FBIT fractional bits
- FBIT, 10: fractional bits of input and output (1.0 = 2^FBIT)
- OBIT, 12: output width, signed; must be ≥ FBIT+2 (≥ FBIT+1 if tanh compiled out)
- SAT_LOG2, 2: saturation knee L = 2^SAT_LOG2 (default 4.0); L·2^FBIT must fit in IBIT-1 bits
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  pipeline clock enable; low freezes all stages
- dv_in  in  1  input sample valid
- mode  in  1  0 = sigmoid, 1 = tanh; sampled with sigin
- sigin  in  IBIT  signed input sample
- dv_out  out  1  output valid, one pulse per accepted sample
- sigout  out  OBIT  signed result, FBIT fractional bits

## Operation
- Accept a sample on a cycle with ce=1 and dv_in=1. No backpressure: a new sample may be accepted every ce cycle.
- Let F=FBIT, S=SAT_LOG2, K=L·2^F. In tanh mode, x=2·sigin, computed in IBIT+1 bits so it cannot overflow. In sigmoid mode, x=sigin.
- Stage 1: neg = x<0; a = min(|x|, K); d = K − a (unsigned, F+S+1 bits). Register neg, mode, d and valid.
- Stage 2: d² (unsigned, 2(F+S+1) bits), registered by the squarer.
- Stage 3: t = (d² + 2^(F+2S)) >> (F+2S+1), i.e. 0.5·(d/L)² with round-half-up.
  - Sigmoid: y = neg ? t : 2^F − t.
  - Tanh: y = neg ? 2t − 2^F : 2^F − 2t.
  - Clamp y to [−(2^F−1), 2^F−1]; in sigmoid mode this gives a range of [0, 2^F−1].
  - Register y into sigout and valid into dv_out.
- |x| ≥ K gives d=0, t=0:
  - sigmoid → 2^F−1 (positive) or 0 (negative);
  - tanh → ±(2^F−1).
- x=0 yields exactly 2^F/2 (sigmoid) or 0 (tanh).
- Negative full-scale input (−2^(IBIT−1)) must clip correctly; no abs overflow.
- Stage registers update only when ce=1.
  - Invalid slots propagate as bubbles (valid=0).
  - sigout holds its last value during bubbles.

## Timing
- Reset values: dv_out=0 and sigout=0; all stage valid bits and data registers are 0.
- Latency: exactly 3 ce-high cycles from acceptance to dv_out=1 with the result. Throughput: 1 sample per ce-high cycle.
- ce=0: no stage advances, dv_out and sigout hold. A sample presented while ce=0 is not accepted.
- mode is per-sample and travels with the data. Back-to-back samples of different modes are legal.
- rst mid-operation discards all in-flight samples. No dv_out pulse may follow for samples accepted before reset. The first sample after rst deasserts is accepted on the next ce-high edge.

## Configuration
- SIGMOID_TANH_EN defined: tanh path (input doubling, 2t arithmetic, symmetric clamp) is compiled in, and mode is honoured.
- SIGMOID_TANH_EN undefined: the mode port remains but is ignored, all samples use sigmoid, and the tanh logic is absent. OBIT ≥ FBIT+1 suffices.

## Structure
- Shared package sigmoid_pkg holds:
  - MODE_SIGMOID=0 and MODE_TANH=1;
  - SIGMOID_LATENCY=3;
  - a function returning the stage-1 d width from F and S.
- One sub-module, sig_square: unsigned registered squarer, 1-cycle latency, with ce. It maps to DSP and stands in for the old multiplier cores.
- Stages 1 and 3 live in sigmoid_pipe.

## Test plan
- Reset/idle: assert rst with dv_in=1 → dv_out=0 and sigout=0 throughout; after release, sigin=0 in sigmoid mode → 512 at cycle 3.
- Sigmoid points (defaults): sigin = 1024, −1024, 5120, −5120, −1 → 736, 288, 1023, 0, 512 respectively, each 3 cycles after acceptance.
- Tanh points: sigin = 1024, −1024, 0, 4096, −2^31 → 768, −768, 0, 1023, −1023.
- Streaming: 1000 random samples back-to-back with random mode → dv_out contiguous and delayed 3 cycles, values bit-exact to the reference model.
- ce stall: deassert ce for 5 cycles with 2 samples in flight → outputs frozen, both results emerge after 3 cumulative ce-high cycles, values unchanged.
- Mid-flight reset: accept 3 samples, pulse rst one cycle after the third → no dv_out pulses until a new sample is accepted.
